card_cmd_sequencer: RTL and testbench
=====================================

Name: card_cmd_sequencer

Overview:
Sequences the SD card driver from a UART byte stream. It parses host command frames from the UART RX side and issues read-address, write-address and write-data transfers to the card driver. Card result bytes and the sequencer's own status bytes are merged onto the single UART TX channel. It sits between dev_uart_asy and card_driver in the tester top level.

Parameters:
BLOCK_BYTES, 512, number of data bytes per write command (range 1..65535).
TIMEOUT_CYC, 50_000_000, number of idle CLK cycles allowed between RX bytes inside a frame before the frame is aborted (minimum 2).

Ports:
CLK  in  1  system clock
nRESET  in  1  asynchronous active-low reset
RX_STB  in  1  UART received-byte strobe
RX_DAT  in  8  UART received byte
RX_ACK  out  1  received byte accepted
TX_STB  out  1  byte to UART transmitter
TX_DAT  out  8  byte to transmit
TX_ACK  in  1  transmitter accepted byte
WR_STB  out  1  write-block request to card driver
WR_ADDR  out  32  write block address
WR_ACK  in  1  write request accepted
WD_STB  out  1  write data byte valid
WD_DATA  out  8  write data byte
WD_ACK  in  1  write data accepted
RD_STB  out  1  read-block request
RD_ADDR  out  32  read block address
RD_ACK  in  1  read request accepted
RES_STB  in  1  card result byte valid
RES_DATA  in  8  card result byte
RES_ACK  out  1  card result byte consumed
BUSY  out  1  high whenever state is not IDLE
ERR  out  1  one-cycle pulse on each abort or unknown command

Behaviour:
- Handshake rule (all STB/ACK pairs):
  - A transfer occurs on a rising CLK edge where STB and ACK are both high.
  - The source holds STB and its data stable until that transfer.
  - STB drops in the cycle after the transfer unless the next item is already registered.
- Reset (nRESET low, asynchronous, including mid-frame):
  - State returns to IDLE.
  - All STB outputs, RX_ACK, RES_ACK, BUSY, ERR, WR_ADDR, RD_ADDR, WD_DATA, TX_DAT and ERR_CNT go to 0.
  - Partial frames are discarded.
- Frame formats:
  - 'R' (0x52) + 4 address bytes, most significant byte first.
  - 'W' (0x57) + 4 address bytes + BLOCK_BYTES data bytes.
  - 'S' (0x53) alone.
- RX_ACK is registered. It is high only in IDLE, ADDR and DATA, and drops in the cycle after each RX transfer.
- States:
  - IDLE:
    - 'R' or 'W' -> ADDR, with the byte counter cleared.
    - 'S' -> STATUS, with byte = ERR_CNT.
    - Any other byte -> STATUS, with byte = 0x3F; ERR pulses; ERR_CNT increments.
  - ADDR:
    - Shifts each byte into the address register (addr <= {addr[23:0], byte}).
    - After the 4th byte: -> ISSUE_RD for 'R', or ISSUE_WR for 'W'.
  - ISSUE_RD: RD_STB=1 with RD_ADDR=addr; on RD_ACK -> IDLE.
  - ISSUE_WR: WR_STB=1 with WR_ADDR=addr; on WR_ACK -> DATA, with data counter = 0.
  - DATA: latches the RX byte into WD_DATA -> PUSH.
  - PUSH:
    - WD_STB=1; on WD_ACK the data counter increments.
    - If the counter reaches BLOCK_BYTES -> STATUS with byte = 0x4B ('K'); otherwise -> DATA.
  - STATUS: the own status byte is pending on TX; once transferred -> IDLE.
- Timeout:
  - A 32-bit counter is cleared on every RX transfer and runs only in ADDR and DATA.
  - On reaching TIMEOUT_CYC -> STATUS with byte = 0x54; ERR pulses; ERR_CNT increments.
  - ISSUE_*/PUSH waits are not timed.
- ERR_CNT: 8-bit internal counter, saturating at 0xFF.
- TX merge:
  - Owner is selected only when TX_STB is low.
  - A pending status byte has priority over RES_STB.
  - While RES owns TX: TX_STB=RES_STB, TX_DAT=RES_DATA, RES_ACK=TX_ACK (combinational pass-through).
  - RES_ACK is 0 while the status byte owns TX.
  - Ownership is held until the owning transfer completes, so there is no mid-byte switch.
  - RES bytes are forwarded in every state, including during command parsing.
- Latency: the 'R' frame's 4th address-byte transfer -> RD_STB high 1 cycle later.

Test Plan:
- 'R',00,00,01,2C sent with RD_ACK tied high -> one RD transfer with RD_ADDR=0x0000012C; BUSY returns low; no TX byte generated.
- BLOCK_BYTES=4; 'W',00,00,00,08,A1,A2,A3,A4; WD_ACK delayed 3 cycles per byte -> WR_ADDR=0x00000008, then WD bytes A1..A4 in order, then TX 0x4B.
- Byte 0x41 in IDLE -> TX 0x3F, ERR one-cycle pulse; a following 'S' -> TX 0x01.
- TIMEOUT_CYC=100; 'R',00 then silence -> TX 0x54 at cycle 100 after the last byte, state IDLE; next 'R'+4 bytes issues a read normally.
- RES_STB high with 0x55 while a status byte is pending, TX_ACK stalled -> status byte goes first, then 0x55 with exactly one RES transfer; no byte lost or duplicated.
- nRESET pulsed low mid-way through the 'W' data phase -> all outputs 0 immediately; a subsequent 'S' returns 0x00.

Source files
------------

// File: rtl/card_cmd_sequencer.sv
// Host command sequencer: parses 'R'/'W'/'S' frames from the UART byte stream, drives the card
// driver request ports and merges card result bytes with its own status bytes onto UART TX.
module card_cmd_sequencer #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        RX_STB,
    input  logic [7:0]  RX_DAT,
    output logic        RX_ACK,
    output logic        TX_STB,
    output logic [7:0]  TX_DAT,
    input  logic        TX_ACK,
    output logic        WR_STB,
    output logic [31:0] WR_ADDR,
    input  logic        WR_ACK,
    output logic        WD_STB,
    output logic [7:0]  WD_DATA,
    input  logic        WD_ACK,
    output logic        RD_STB,
    output logic [31:0] RD_ADDR,
    input  logic        RD_ACK,
    input  logic        RES_STB,
    input  logic [7:0]  RES_DATA,
    output logic        RES_ACK,
    output logic        BUSY,
    output logic        ERR,
    output logic [2:0]  DBG_STATE
);
    // Every STB/ACK pair: a transfer happens on a rising CLK edge with STB and ACK both high; the
    // source holds STB and data stable until then and drops STB afterwards unless more is queued.
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ISSUE_RD, S_ISSUE_WR, S_DATA, S_PUSH, S_STATUS
    } state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_STAT, OWN_RES} own_t;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [15:0] DATA_LAST = 16'(BLOCK_BYTES - 1);

    state_t      state_q, state_d;
    own_t        own_q, own_d, own_sel;
    logic        cmd_wr_q, cmd_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] data_cnt_q, data_cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  wd_data_q, wd_data_d;
    logic [7:0]  stat_byte_q, stat_byte_d;
    logic        rx_ack_q, rx_ack_d;
    logic        err_q, err_d;
    logic        err_inc, rx_xfer, tx_xfer, timed, tmo_hit;

    assign rx_xfer   = RX_STB && rx_ack_q;
    assign RX_ACK    = rx_ack_q;
    assign WR_STB    = (state_q == S_ISSUE_WR);
    assign RD_STB    = (state_q == S_ISSUE_RD);
    assign WD_STB    = (state_q == S_PUSH);
    assign WR_ADDR   = addr_q;
    assign RD_ADDR   = addr_q;
    assign WD_DATA   = wd_data_q;
    assign BUSY      = (state_q != S_IDLE);
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

    // A new TX owner is only picked while nobody holds the channel; the status byte wins ties.
    always_comb begin
        own_sel = own_q;
        if (own_q == OWN_NONE) begin
            if (state_q == S_STATUS) own_sel = OWN_STAT;
            else if (RES_STB)        own_sel = OWN_RES;
        end
        TX_STB  = (own_sel == OWN_STAT) || ((own_sel == OWN_RES) && RES_STB);
        TX_DAT  = 8'h00;
        if (own_sel == OWN_STAT)     TX_DAT = stat_byte_q;
        else if (own_sel == OWN_RES) TX_DAT = RES_DATA;
        RES_ACK = (own_sel == OWN_RES) && TX_ACK;
        tx_xfer = TX_STB && TX_ACK;
        own_d   = own_q;
        if (tx_xfer)     own_d = OWN_NONE;
        else if (TX_STB) own_d = own_sel;
    end

    always_comb begin
        state_d     = state_q;
        cmd_wr_d    = cmd_wr_q;
        addr_d      = addr_q;
        byte_cnt_d  = byte_cnt_q;
        data_cnt_d  = data_cnt_q;
        wd_data_d   = wd_data_q;
        stat_byte_d = stat_byte_q;
        err_d       = 1'b0;
        err_inc     = 1'b0;
        timed       = (state_q == S_ADDR) || (state_q == S_DATA);
        tmo_d       = (rx_xfer || !timed) ? 32'd0 : tmo_q + 32'd1;
        tmo_hit     = timed && !rx_xfer && (tmo_q == TMO_LAST);
        case (state_q)
            S_IDLE: if (rx_xfer) begin
                if (RX_DAT == 8'h52 || RX_DAT == 8'h57) begin
                    state_d    = S_ADDR;
                    cmd_wr_d   = (RX_DAT == 8'h57);
                    byte_cnt_d = 2'd0;
                end else if (RX_DAT == 8'h53) begin
                    state_d     = S_STATUS;
                    stat_byte_d = err_cnt_q;
                end else begin
                    state_d     = S_STATUS;
                    stat_byte_d = 8'h3F;
                    err_d       = 1'b1;
                    err_inc     = 1'b1;
                end
            end
            S_ADDR: if (rx_xfer) begin
                addr_d     = {addr_q[23:0], RX_DAT};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) state_d = cmd_wr_q ? S_ISSUE_WR : S_ISSUE_RD;
            end
            S_ISSUE_RD: if (RD_ACK) state_d = S_IDLE;
            S_ISSUE_WR: if (WR_ACK) begin
                state_d    = S_DATA;
                data_cnt_d = 16'd0;
            end
            S_DATA: if (rx_xfer) begin
                wd_data_d = RX_DAT;
                state_d   = S_PUSH;
            end
            S_PUSH: if (WD_ACK) begin
                data_cnt_d = data_cnt_q + 16'd1;
                if (data_cnt_q == DATA_LAST) begin
                    state_d     = S_STATUS;
                    stat_byte_d = 8'h4B;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STATUS: if (tx_xfer && own_sel == OWN_STAT) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d     = S_STATUS;
            stat_byte_d = 8'h54;
            err_d       = 1'b1;
            err_inc     = 1'b1;
        end
        err_cnt_d = err_cnt_q;
        if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        // Registered accept: low for one cycle after every RX transfer and outside parsing states.
        rx_ack_d = !rx_xfer &&
                   (state_d == S_IDLE || state_d == S_ADDR || state_d == S_DATA);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= S_IDLE;
            own_q       <= OWN_NONE;
            cmd_wr_q    <= 1'b0;
            addr_q      <= 32'd0;
            byte_cnt_q  <= 2'd0;
            data_cnt_q  <= 16'd0;
            tmo_q       <= 32'd0;
            err_cnt_q   <= 8'd0;
            wd_data_q   <= 8'd0;
            stat_byte_q <= 8'd0;
            rx_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            cmd_wr_q    <= cmd_wr_d;
            addr_q      <= addr_d;
            byte_cnt_q  <= byte_cnt_d;
            data_cnt_q  <= data_cnt_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
            wd_data_q   <= wd_data_d;
            stat_byte_q <= stat_byte_d;
            rx_ack_q    <= rx_ack_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_card_cmd_sequencer.sv
// Directed bench for card_cmd_sequencer with BLOCK_BYTES=4 and TIMEOUT_CYC=100.
module tb_card_cmd_sequencer;
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        rx_stb = 1'b0, tx_ack = 1'b1, wr_ack = 1'b1, wd_ack = 1'b0;
  logic        rd_ack = 1'b1, res_stb = 1'b0;
  logic [7:0]  rx_dat = 8'h00, res_data = 8'h00;
  logic        rx_ack, tx_stb, wr_stb, wd_stb, rd_stb, res_ack, busy, err;
  logic [7:0]  tx_dat, wd_data;
  logic [31:0] wr_addr, rd_addr;
  logic [2:0]  dbg_state;

  logic [7:0]  tx_q[$];
  logic [7:0]  wd_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [7:0]  exp_q[$];
  int          res_xfers = 0;
  int          wd_wait = 0;
  int          checks = 0;
  int          failures = 0;

  card_cmd_sequencer #(.BLOCK_BYTES(4), .TIMEOUT_CYC(100)) dut (
    .CLK(clk), .nRESET(n_reset),
    .RX_STB(rx_stb), .RX_DAT(rx_dat), .RX_ACK(rx_ack),
    .TX_STB(tx_stb), .TX_DAT(tx_dat), .TX_ACK(tx_ack),
    .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_ACK(wr_ack),
    .WD_STB(wd_stb), .WD_DATA(wd_data), .WD_ACK(wd_ack),
    .RD_STB(rd_stb), .RD_ADDR(rd_addr), .RD_ACK(rd_ack),
    .RES_STB(res_stb), .RES_DATA(res_data), .RES_ACK(res_ack),
    .BUSY(busy), .ERR(err), .DBG_STATE(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // transfer monitors: inputs change 1ns after posedge, so negedge values hold to the next edge
  always @(negedge clk) begin
    if (tx_stb && tx_ack) tx_q.push_back(tx_dat);
    if (wd_stb && wd_ack) wd_q.push_back(wd_data);
    if (rd_stb && rd_ack) rd_q.push_back(rd_addr);
    if (wr_stb && wr_ack) wr_q.push_back(wr_addr);
    if (res_stb && res_ack) res_xfers++;
  end

  // card write-data sink acknowledging each byte a few cycles late
  always @(posedge clk) begin
    #1;
    if (wd_ack) wd_ack = 1'b0;
    else if (wd_stb) begin
      if (wd_wait == 3) begin
        wd_ack  = 1'b1;
        wd_wait = 0;
      end else wd_wait++;
    end else wd_wait = 0;
  end

  // driver tasks
  task automatic send_rx(input logic [7:0] b);
    int n = 0;
    rx_stb = 1'b1;
    rx_dat = b;
    @(negedge clk);
    while (!rx_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rx_ack) begin
      failures++;
      $display("FAIL rx_accept: byte %02h not accepted, rx_ack=%0b required 1", b, rx_ack);
    end
    @(posedge clk);
    #1;
    rx_stb = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_q.size() < n) begin
      failures++;
      $display("FAIL tx_wait: got %0d tx bytes required %0d", tx_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tx_q.delete();
    wd_q.delete();
    rd_q.delete();
    wr_q.delete();
    exp_q.delete();
    res_xfers = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, rx_ack, tx_stb, wr_stb, wd_stb, rd_stb, res_ack, err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags: got %08b required 00000000",
               {busy, rx_ack, tx_stb, wr_stb, wd_stb, rd_stb, res_ack, err});
    end
    checks++;
    if ({wr_addr, rd_addr, wd_data, tx_dat} !== 80'h0) begin
      failures++;
      $display("FAIL reset_data: got %h required 0", {wr_addr, rd_addr, wd_data, tx_dat});
    end
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rx_ack !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got rx_ack=%0b busy=%0b required 1 0", rx_ack, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    clear_logs();
    send_rx(8'h52);
    send_rx(8'h00);
    send_rx(8'h00);
    send_rx(8'h01);
    send_rx(8'h2C);
    @(negedge clk);
    checks++;
    if (rd_stb !== 1'b1 || rd_addr !== 32'h0000012C) begin
      failures++;
      $display("FAIL read_latency: got rd_stb=%0b rd_addr=%h required 1 0000012c", rd_stb, rd_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() !== 1 || rd_q[0] !== 32'h0000012C) begin
      failures++;
      $display("FAIL read_xfer: got %0d transfers required 1 at 0000012c", rd_q.size());
    end
    checks++;
    if (busy !== 1'b0 || tx_q.size() !== 0) begin
      failures++;
      $display("FAIL read_idle: got busy=%0b tx_bytes=%0d required 0 0", busy, tx_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    clear_logs();
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_rx(8'h57);
    send_rx(8'h00);
    send_rx(8'h00);
    send_rx(8'h00);
    send_rx(8'h08);
    for (int i = 0; i < 4; i++) send_rx(exp_q[i]);
    wait_tx(1);
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== 32'h00000008) begin
      failures++;
      $display("FAIL write_addr: got %0d requests required 1 at 00000008", wr_q.size());
    end
    checks++;
    if (wd_q.size() !== 4) begin
      failures++;
      $display("FAIL write_count: got %0d data bytes required 4", wd_q.size());
    end
    for (int i = 0; i < 4 && i < wd_q.size(); i++) begin
      checks++;
      if (wd_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL write_data[%0d]: got %02h required %02h", i, wd_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
      failures++;
      $display("FAIL write_status: got %02h required 4b", tx_q[0]);
    end
  endtask

  task automatic test_unknown();
    clear_logs();
    send_rx(8'h41);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL unknown_err_pulse: got err=%0b required 1", err);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL unknown_err_width: got err=%0b required 0", err);
    end
    @(posedge clk);
    #1;
    wait_tx(1);
    send_rx(8'h53);
    wait_tx(2);
    checks++;
    if (tx_q[0] !== 8'h3F || tx_q[1] !== 8'h01) begin
      failures++;
      $display("FAIL unknown_status: got %02h %02h required 3f 01", tx_q[0], tx_q[1]);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_logs();
    send_rx(8'h52);
    send_rx(8'h00);
    while (!tx_stb && n < 300) begin
      @(posedge clk);
      n++;
      #1;
    end
    checks++;
    if (n !== 100 || tx_dat !== 8'h54 || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fire: got cycle %0d byte %02h err %0b required 100 54 1", n, tx_dat, err);
    end
    wait_tx(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: got busy=%0b required 0", busy);
    end
    send_rx(8'h52);
    send_rx(8'hDE);
    send_rx(8'hAD);
    send_rx(8'hBE);
    send_rx(8'hEF);
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() !== 1 || rd_q[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL timeout_recover: got %0d reads required 1 at deadbeef", rd_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    clear_logs();
    tx_ack = 1'b0;
    send_rx(8'h53);
    res_stb  = 1'b1;
    res_data = 8'h55;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_stb !== 1'b1 || tx_dat !== 8'h02 || res_ack !== 1'b0) begin
      failures++;
      $display("FAIL merge_stall: got stb=%0b dat=%02h res_ack=%0b required 1 02 0",
               tx_stb, tx_dat, res_ack);
    end
    @(posedge clk);
    #1;
    tx_ack = 1'b1;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (res_stb && res_ack) break;
    end
    @(posedge clk);
    #1;
    res_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (tx_q.size() !== 2 || res_xfers !== 1) begin
      failures++;
      $display("FAIL merge_count: got %0d tx bytes %0d res transfers required 2 1",
               tx_q.size(), res_xfers);
    end
    checks++;
    if (tx_q.size() >= 2 && (tx_q[0] !== 8'h02 || tx_q[1] !== 8'h55)) begin
      failures++;
      $display("FAIL merge_order: got %02h %02h required 02 55", tx_q[0], tx_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_rx(8'h57);
    for (int i = 0; i < 4; i++) send_rx(8'h00);
    send_rx(8'hC1);
    send_rx(8'hC2);
    #3;
    n_reset = 1'b0;
    #1;
    checks++;
    if ({busy, rx_ack, tx_stb, wr_stb, wd_stb, rd_stb, res_ack, err} !== 8'h00) begin
      failures++;
      $display("FAIL midreset_flags: got %08b required 00000000",
               {busy, rx_ack, tx_stb, wr_stb, wd_stb, rd_stb, res_ack, err});
    end
    checks++;
    if ({wr_addr, rd_addr, wd_data, tx_dat} !== 80'h0) begin
      failures++;
      $display("FAIL midreset_data: got %h required 0", {wr_addr, rd_addr, wd_data, tx_dat});
    end
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    send_rx(8'h53);
    wait_tx(1);
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h00) begin
      failures++;
      $display("FAIL midreset_status: got %02h (%0d bytes) required 00 (1 byte)", tx_q[0], tx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unknown();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
